pwm_multi_channel_driver: RTL and testbench

Parametrised multi-channel PWM generator, successor to the team's single-purpose TinyTapeout counter blocks. It is loaded over a minimal write-only SPI port and drives `CHANNELS` outputs with `WIDTH`-bit duty cycles. Duty values are double-buffered, so updates take effect only at a period boundary and glitch-free. The block sits directly between the chip's `io_in` pins (clock, reset, SPI) and the `io_out` pins (PWM lines).

---
 rtl/pwm_multi_channel_driver.sv | 121 ++++++++++++
 tb/tb_pwm_multi_channel_driver.sv | 137 +++++++++++++
 2 files changed

// File: rtl/pwm_multi_channel_driver.sv
// rtl/pwm_multi_channel_driver.sv - multi-channel double-buffered PWM generator loaded over write-only SPI
// Optional macro PWM_PHASE_STAGGER_EN offsets each channel's compare value to spread rising edges.
module pwm_multi_channel_driver #(
  parameter int CHANNELS = 7,
  parameter int WIDTH    = 3,
  parameter int PRESCALE = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                spi_sck,
  input  logic                spi_mosi,
  input  logic                spi_cs_n,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                period_start
);
  localparam int ADDR_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int AW1    = ADDR_W + 1;
  localparam int FRAME  = ADDR_W + WIDTH;
  localparam int BC_W   = $clog2(FRAME + 2);
  localparam int PRE_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int PERIOD = (1 << WIDTH) - 1;

  localparam logic [BC_W-1:0]  BC_FULL = BC_W'(FRAME);
  localparam logic [BC_W-1:0]  BC_SAT  = BC_W'(FRAME + 1);
  localparam logic [ADDR_W:0]  CH_LIM  = AW1'(CHANNELS);
  localparam logic [PRE_W-1:0] PRE_TOP = PRE_W'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] CNT_TOP = WIDTH'(PERIOD - 1);

  logic [1:0]       sck_sync, mosi_sync, cs_sync;
  logic             sck_prev, cs_prev;
  logic             sck_rise, cs_rise, cs_fall;
  logic [FRAME-1:0] shift;
  logic [BC_W-1:0]  bitcnt;
  logic [ADDR_W-1:0] addr;
  logic [WIDTH-1:0] duty;
  logic             commit;

  logic [PRE_W-1:0] pre;
  logic [WIDTH-1:0] cnt;
  logic             tick, wrap;
  logic [WIDTH-1:0] shadow [CHANNELS];
  logic [WIDTH-1:0] active [CHANNELS];
  logic [WIDTH-1:0] cmp    [CHANNELS];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sck_sync  <= 2'b00;
      mosi_sync <= 2'b00;
      cs_sync   <= 2'b11;
      sck_prev  <= 1'b0;
      cs_prev   <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[0], spi_sck};
      mosi_sync <= {mosi_sync[0], spi_mosi};
      cs_sync   <= {cs_sync[0], spi_cs_n};
      sck_prev  <= sck_sync[1];
      cs_prev   <= cs_sync[1];
    end
  end

  assign sck_rise = sck_sync[1] & ~sck_prev;
  assign cs_rise  = cs_sync[1] & ~cs_prev;
  assign cs_fall  = ~cs_sync[1] & cs_prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift  <= '0;
      bitcnt <= '0;
    end else if (cs_fall) begin
      shift  <= '0;
      bitcnt <= '0;
    end else if (sck_rise && !cs_sync[1]) begin
      shift <= {shift[FRAME-2:0], mosi_sync[1]};
      if (bitcnt != BC_SAT) bitcnt <= bitcnt + 1'b1;
    end
  end

  // Short, long and out-of-range frames fall through without touching shadow.
  assign addr   = shift[FRAME-1:WIDTH];
  assign duty   = shift[WIDTH-1:0];
  assign commit = cs_rise && (bitcnt == BC_FULL) && ({1'b0, addr} < CH_LIM);

  assign tick = (pre == PRE_TOP);
  assign wrap = tick && (cnt == CNT_TOP);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_cmp
`ifdef PWM_PHASE_STAGGER_EN
    localparam int OFS = (g * (PERIOD / CHANNELS)) % PERIOD;
    localparam logic [WIDTH:0] PER_X = AW1'(0) + (WIDTH+1)'(PERIOD);
    logic [WIDTH:0] sum;
    assign sum = {1'b0, cnt} + (WIDTH+1)'(OFS);
    // Subtracting 2^WIDTH-1 equals dropping the carry bit and adding one.
    assign cmp[g] = (sum >= PER_X) ? sum[WIDTH-1:0] + 1'b1 : sum[WIDTH-1:0];
`else
    assign cmp[g] = cnt;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre          <= '0;
      cnt          <= '0;
      period_start <= 1'b0;
      pwm_out      <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      pre <= tick ? '0 : pre + 1'b1;
      if (tick) cnt <= (cnt == CNT_TOP) ? '0 : cnt + 1'b1;
      period_start <= wrap;
      // A commit in the wrap cycle lands in shadow after active already sampled it.
      for (int i = 0; i < CHANNELS; i++) begin
        if (commit && (addr == ADDR_W'(i))) shadow[i] <= duty;
        if (wrap) active[i] <= shadow[i];
        pwm_out[i] <= (cmp[i] < active[i]);
      end
    end
  end
endmodule

// File: tb/tb_pwm_multi_channel_driver.sv
// tb/tb_pwm_multi_channel_driver.sv - directed self-checking bench for pwm_multi_channel_driver
module tb_pwm_multi_channel_driver;
  logic       clk = 1'b0;
  logic       reset_n;
  logic       spi_sck;
  logic       spi_mosi;
  logic       spi_cs_n;
  logic [6:0] pwm_out;
  logic       period_start;

  int vectors = 0;
  int miscompares = 0;
  int duty_exp [7];

  pwm_multi_channel_driver dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .spi_sck      (spi_sck),
    .spi_mosi     (spi_mosi),
    .spi_cs_n     (spi_cs_n),
    .pwm_out      (pwm_out),
    .period_start (period_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [15:0] bits, input int n, input bit raise);
    spi_cs_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = n - 1; k >= 0; k--) begin
      spi_mosi = bits[k];
      repeat (3) @(negedge clk);
      spi_sck = 1'b1;
      repeat (3) @(negedge clk);
      spi_sck = 1'b0;
    end
    repeat (3) @(negedge clk);
    if (raise) begin
      spi_cs_n = 1'b1;
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic wait_ps();
    bit found = 1'b0;
    for (int t = 0; t < 30 && !found; t++) begin
      @(negedge clk);
      if (period_start) found = 1'b1;
    end
    chk("ps_found", {31'd0, found}, 32'd1);
  endtask

  // Called right after the negedge that sees period_start; step j reflects cnt==j-1.
  task automatic check_period(input string tag);
    logic [6:0] exp;
    for (int j = 1; j <= 7; j++) begin
      @(negedge clk);
      for (int i = 0; i < 7; i++) exp[i] = ((j - 1) < duty_exp[i]);
      chk({tag, "_pwm"}, {25'd0, pwm_out}, {25'd0, exp});
      chk({tag, "_ps"}, {31'd0, period_start}, {31'd0, (j == 7)});
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    spi_sck  = 1'b0;
    spi_mosi = 1'b0;
    spi_cs_n = 1'b1;
    for (int i = 0; i < 7; i++) duty_exp[i] = 0;

    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      spi_sck  = ~spi_sck;
      spi_mosi = ~spi_mosi;
      spi_cs_n = ~spi_cs_n;
      chk("rst_pwm", {25'd0, pwm_out}, 32'd0);
      chk("rst_ps", {31'd0, period_start}, 32'd0);
    end
    spi_sck  = 1'b0;
    spi_mosi = 1'b0;
    spi_cs_n = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;

    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      chk("first_ps", {31'd0, period_start}, {31'd0, (k == 7)});
      chk("first_pwm", {25'd0, pwm_out}, 32'd0);
    end
    check_period("idle");

    send_frame(16'b010_011, 6, 1'b1);
    wait_ps();
    duty_exp[2] = 3;
    check_period("ch2_d3");

    send_frame(16'b000_111, 6, 1'b1);
    send_frame(16'b001_000, 6, 1'b1);
    wait_ps();
    duty_exp[0] = 7;
    check_period("ch0_full");

    send_frame(16'b01011, 5, 1'b1);
    send_frame(16'b0011110, 7, 1'b1);
    send_frame(16'b111_101, 6, 1'b1);
    wait_ps();
    check_period("bad_frames");

    send_frame(16'b100_101, 6, 1'b0);
    wait_ps();
    repeat (4) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("wrap_commit_ps", {31'd0, period_start}, 32'd1);
    check_period("old_at_wrap");
    duty_exp[4] = 5;
    check_period("ch4_d5");

    @(negedge clk);
    chk("pre_reset_ch2", {31'd0, pwm_out[2]}, 32'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("async_rst_pwm", {25'd0, pwm_out}, 32'd0);
    chk("async_rst_ps", {31'd0, period_start}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
